// File: rtl/coreuart_sync_fifo.sv
// Parametrised single-clock FIFO for the CoreUART RX/TX paths, with inferred RAM storage.
// Latency: a read returns registered data on DO one cycle after RE; written data is readable from the next cycle.
// Backpressure: a write into a full FIFO is dropped unless paired with a read; refused accesses raise sticky OVF/UDF.
module coreuart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CLR,
  input  logic                  WE,
  input  logic [WIDTH-1:0]      DI,
  input  logic                  RE,
  output logic [WIDTH-1:0]      DO,
  output logic                  DVALID,
  input  logic [DEPTH_LOG2:0]   AFULL_LVL,
  input  logic [DEPTH_LOG2:0]   AEMPTY_LVL,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  AFULL,
  output logic                  AEMPTY,
  output logic                  OVF,
  output logic                  UDF
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Occupancy value meaning "full": only the top bit of COUNT set.
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [DEPTH_LOG2-1:0] rp_q, rp_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      do_q, do_d;
  logic                  dvalid_q, dvalid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty;
  logic                  wr_ok, rd_ok;

  // Status flags are plain decodes of the registered occupancy.
  always_comb begin
    full  = (count_q == DEPTH_CNT);
    empty = (count_q == '0);
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    // A flush overrides both ports.
    wr_ok = WE & (~full | RE) & ~CLR;
    rd_ok = RE & ~empty & ~CLR;
  end

  // Next-state for pointers, occupancy, read register and sticky error flags.
  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    do_d     = do_q;
    dvalid_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (CLR) begin
      // Flush resets bookkeeping only; DO and RAM contents are left alone.
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      // Pointers wrap silently; COUNT tells full from empty.
      wp_d     = wp_q + DEPTH_LOG2'(wr_ok);
      rp_d     = rp_q + DEPTH_LOG2'(rd_ok);
      count_d  = count_q + (DEPTH_LOG2+1)'(wr_ok) - (DEPTH_LOG2+1)'(rd_ok);
      dvalid_d = rd_ok;
      if (rd_ok) begin
        do_d = mem_q[rp_q];
      end
      if (WE & full & ~RE) begin
        ovf_d = 1'b1;
      end
      if (RE & empty) begin
        udf_d = 1'b1;
      end
    end
  end

  // Storage write port; no reset so the array maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem_q[wp_q] <= DI;
    end
  end

  // Control state and the RAM output register, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      do_q     <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      do_q     <= do_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Threshold compares are unsigned, so level 0 pins AFULL high and levels above DEPTH pin it low.
  always_comb begin
    DO     = do_q;
    DVALID = dvalid_q;
    COUNT  = count_q;
    FULL   = full;
    EMPTY  = empty;
    AFULL  = (count_q >= AFULL_LVL);
    AEMPTY = (count_q <= AEMPTY_LVL);
    OVF    = ovf_q;
    UDF    = udf_q;
  end

endmodule
